// File: rtl/check_node_scheduler_pkg.sv
// check_node_scheduler_pkg: shared state encoding and sizing constants for the check-node scheduler
package check_node_scheduler_pkg;
    localparam int NUM_CHECKS_DEF = 16;
    localparam int MAX_ITER_DEF = 10;
    localparam int CHECK_BIT_DEF = $clog2(NUM_CHECKS_DEF);
    localparam int ITER_BIT_DEF = $clog2(MAX_ITER_DEF + 1);
    localparam int CN_CYCLES_PER_CHECK = 4;
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_PHASE,
        S_WRITE,
        S_ITER_END,
        S_FINISH
    } sched_state_t;
endpackage

// File: rtl/check_node_scheduler_if.sv
// check_node_scheduler_if: decoder control, message-memory and CheckNode control signals of the scheduler
interface check_node_scheduler_if #(
    parameter int CHECK_BIT = 4,
    parameter int ITER_BIT = 4
);
    logic                 START;
    logic [ITER_BIT-1:0]  ITER_LIMIT;
    logic                 ABORT;
    logic                 SYNDROME_OK;
    logic                 BUSY;
    logic                 DONE;
    logic                 SUCCESS;
    logic [ITER_BIT-1:0]  ITER_COUNT;
    logic                 RD_EN;
    logic [CHECK_BIT-1:0] RD_ADDR;
    logic                 WR_EN;
    logic [CHECK_BIT-1:0] WR_ADDR;
    logic                 WR_READY;
    logic                 CN_CLK_STATE;
    logic                 CN_RST;
    modport master (
        output START, ITER_LIMIT, ABORT, SYNDROME_OK, WR_READY,
        input  BUSY, DONE, SUCCESS, ITER_COUNT, RD_EN, RD_ADDR, WR_EN, WR_ADDR, CN_CLK_STATE, CN_RST
    );
    modport slave (
        input  START, ITER_LIMIT, ABORT, SYNDROME_OK, WR_READY,
        output BUSY, DONE, SUCCESS, ITER_COUNT, RD_EN, RD_ADDR, WR_EN, WR_ADDR, CN_CLK_STATE, CN_RST
    );
endinterface

// File: rtl/sched_iter_counter.sv
// sched_iter_counter: check-row and iteration counters with the clamped iteration limit
module sched_iter_counter #(
    parameter int NUM_CHECKS = 16,
    parameter int MAX_ITER = 10,
    parameter int CHECK_BIT = 4,
    parameter int ITER_BIT = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [ITER_BIT-1:0]  iter_limit,
    input  logic                 next_check,
    input  logic                 iter_end,
    output logic [CHECK_BIT-1:0] check,
    output logic [ITER_BIT-1:0]  iter,
    output logic                 last_check,
    output logic                 last_iter
);
    logic [CHECK_BIT-1:0] check_q, check_d;
    logic [ITER_BIT-1:0]  iter_q, iter_d, limit_q, limit_d;

    // A zero request still runs one iteration; larger requests saturate at MAX_ITER
    always_comb begin
        check_d = check_q;
        iter_d  = iter_q;
        limit_d = limit_q;
        if (start) begin
            check_d = '0;
            iter_d  = '0;
            limit_d = (iter_limit == '0) ? ITER_BIT'(1)
                    : (iter_limit > ITER_BIT'(MAX_ITER)) ? ITER_BIT'(MAX_ITER) : iter_limit;
        end else if (next_check) begin
            check_d = check_q + CHECK_BIT'(1);
        end else if (iter_end) begin
            check_d = '0;
            iter_d  = iter_q + ITER_BIT'(1);
        end
    end

    // Counter registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            check_q <= '0;
            iter_q  <= '0;
            limit_q <= ITER_BIT'(1);
        end else begin
            check_q <= check_d;
            iter_q  <= iter_d;
            limit_q <= limit_d;
        end
    end

    assign check      = check_q;
    assign iter       = iter_q;
    assign last_check = check_q == CHECK_BIT'(NUM_CHECKS - 1);
    assign last_iter  = (iter_q + ITER_BIT'(1)) == limit_q;
endmodule

// File: rtl/check_node_scheduler.sv
// check_node_scheduler: steps one CheckNode through every check row for up to MAX_ITER iterations
module check_node_scheduler
    import check_node_scheduler_pkg::*;
#(
    parameter int NUM_CHECKS = NUM_CHECKS_DEF,
    parameter int CHECK_BIT = CHECK_BIT_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int ITER_BIT = ITER_BIT_DEF
) (
    input logic                  CLK,
    input logic                  RST,
    check_node_scheduler_if.slave bus
);
    sched_state_t         state_q, state_d;
    logic                 cn_rst_q, cn_rst_d, success_q, success_d;
    logic                 start_ok, abort_ok, next_check, iter_end, last_check, last_iter;
    logic [CHECK_BIT-1:0] check;
    logic [ITER_BIT-1:0]  iter;

    assign start_ok   = (state_q == S_IDLE) && bus.START && !bus.ABORT;
    assign abort_ok   = (state_q != S_IDLE) && bus.ABORT;
    assign next_check = (state_q == S_WRITE) && bus.WR_READY && !last_check && !bus.ABORT;
    assign iter_end   = (state_q == S_ITER_END) && !bus.ABORT;

    sched_iter_counter #(
        .NUM_CHECKS(NUM_CHECKS),
        .MAX_ITER(MAX_ITER),
        .CHECK_BIT(CHECK_BIT),
        .ITER_BIT(ITER_BIT)
    ) u_cnt (
        .CLK(CLK),
        .RST(RST),
        .start(start_ok),
        .iter_limit(bus.ITER_LIMIT),
        .next_check(next_check),
        .iter_end(iter_end),
        .check(check),
        .iter(iter),
        .last_check(last_check),
        .last_iter(last_iter)
    );

    // Next state; an abort overrides everything and pulses the CheckNode reset to realign its STATE
    always_comb begin
        state_d   = state_q;
        success_d = success_q;
        cn_rst_d  = abort_ok;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d   = S_READ;
                    success_d = 1'b0;
                end
            end
            S_READ:  state_d = S_LOAD;
            S_LOAD:  state_d = S_PHASE;
            S_PHASE: state_d = S_WRITE;
            S_WRITE: begin
                if (bus.WR_READY) state_d = last_check ? S_ITER_END : S_READ;
            end
            S_ITER_END: begin
                state_d   = (bus.SYNDROME_OK || last_iter) ? S_FINISH : S_READ;
                success_d = bus.SYNDROME_OK;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort_ok) state_d = S_IDLE;
    end

    // State and status registers; CheckNode reset is held through async reset and released one clock later
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            success_q <= 1'b0;
            cn_rst_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            success_q <= success_d;
            cn_rst_q  <= cn_rst_d;
        end
    end

    assign bus.BUSY         = state_q != S_IDLE;
    assign bus.DONE         = state_q == S_FINISH;
    assign bus.SUCCESS      = success_q;
    assign bus.ITER_COUNT   = iter;
    assign bus.RD_EN        = state_q == S_READ;
    assign bus.RD_ADDR      = check;
    assign bus.WR_EN        = state_q == S_WRITE;
    assign bus.WR_ADDR      = check;
    assign bus.CN_CLK_STATE = !((state_q == S_LOAD) || (state_q == S_PHASE));
    assign bus.CN_RST       = cn_rst_q;
endmodule

// File: tb/tb_check_node_scheduler.sv
// tb_check_node_scheduler: directed scenarios for the check-node scheduler with hand-computed expectations
module tb_check_node_scheduler;
    import check_node_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int dk, nr, re, lo, fw;
    logic sc;
    logic [3:0] ic;

    check_node_scheduler_if #(.CHECK_BIT(4), .ITER_BIT(4)) bus ();
    check_node_scheduler dut (.CLK(clk), .RST(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic start_decode(input logic [3:0] lim);
        bus.ITER_LIMIT = lim;
        bus.START = 1'b1;
        @(posedge clk);
        #1 bus.START = 1'b0;
    endtask

    // Negedge k is the k-th negedge after the accepting edge; with WR_READY high DONE appears at k = iterations*65+1
    task automatic run_to_done(input int base, output int done_k, output int reads, output int rd_errs,
                               output int low, output int first_wr, output logic succ, output logic [3:0] icnt);
        logic [3:0] exp_addr;
        done_k = -1; reads = 0; rd_errs = 0; low = 0; first_wr = 0; succ = 1'bx; icnt = 'x;
        for (int k = 1; k <= 2000 && done_k < 0; k++) begin
            @(negedge clk);
            if (bus.RD_EN) begin
                exp_addr = 4'((base + reads) % 16);
                if (bus.RD_ADDR !== exp_addr) rd_errs++;
                reads++;
            end
            if (!bus.CN_CLK_STATE) low++;
            if (bus.WR_EN && first_wr == 0) first_wr = k;
            if (bus.DONE) begin
                done_k = k;
                succ = bus.SUCCESS;
                icnt = bus.ITER_COUNT;
            end
        end
        @(negedge clk);
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_done: got %b expected 0", bus.BUSY);
        end
    endtask

    task automatic wait_rd(input logic [3:0] a);
        logic found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            found = bus.RD_EN && bus.RD_ADDR == a;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_rd_%0d: got no read expected read of row %0d", a, a);
        end
    endtask

    task automatic test_reset();
        bus.START = 0; bus.ABORT = 0; bus.SYNDROME_OK = 0; bus.WR_READY = 1; bus.ITER_LIMIT = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.BUSY, bus.DONE, bus.SUCCESS, bus.RD_EN, bus.WR_EN} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {bus.BUSY, bus.DONE, bus.SUCCESS, bus.RD_EN, bus.WR_EN});
        end
        checks++;
        if ({bus.ITER_COUNT, bus.RD_ADDR, bus.WR_ADDR} !== 12'h0) begin
            errors++;
            $display("FAIL reset_counts: got %h expected 000", {bus.ITER_COUNT, bus.RD_ADDR, bus.WR_ADDR});
        end
        checks++;
        if ({bus.CN_CLK_STATE, bus.CN_RST} !== 2'b11) begin
            errors++;
            $display("FAIL reset_cn: got %b expected 11", {bus.CN_CLK_STATE, bus.CN_RST});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.CN_RST !== 1'b0) begin
            errors++;
            $display("FAIL cn_rst_release: got %b expected 0", bus.CN_RST);
        end
    endtask

    task automatic test_two_iter();
        bus.SYNDROME_OK = 0;
        start_decode(2);
        checks++;
        if (bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b expected 1", bus.BUSY);
        end
        run_to_done(0, dk, nr, re, lo, fw, sc, ic);
        checks++; if (re !== 0)  begin errors++; $display("FAIL two_rd_addr: got %0d bad rows expected 0", re); end
        checks++; if (nr !== 32) begin errors++; $display("FAIL two_reads: got %0d expected 32", nr); end
        checks++; if (lo !== 64) begin errors++; $display("FAIL two_cn_advance: got %0d expected 64", lo); end
        checks++; if (fw !== CN_CYCLES_PER_CHECK) begin errors++; $display("FAIL first_wr_latency: got %0d expected 4", fw); end
        // 131 edges after the accepting edge, i.e. cycle 132 when the START cycle is cycle 1
        checks++; if (dk !== 131) begin errors++; $display("FAIL two_done_cycle: got %0d expected 131", dk); end
        checks++; if (sc !== 1'b0) begin errors++; $display("FAIL two_success: got %b expected 0", sc); end
        checks++; if (ic !== 4'd2) begin errors++; $display("FAIL two_iter_count: got %0d expected 2", ic); end
        checks++; if (bus.ITER_COUNT !== 4'd2) begin errors++; $display("FAIL two_iter_held: got %0d expected 2", bus.ITER_COUNT); end
    endtask

    task automatic test_syndrome();
        bus.SYNDROME_OK = 1;
        start_decode(5);
        run_to_done(0, dk, nr, re, lo, fw, sc, ic);
        checks++; if (dk !== 66)   begin errors++; $display("FAIL syn_done_cycle: got %0d expected 66", dk); end
        checks++; if (sc !== 1'b1) begin errors++; $display("FAIL syn_success: got %b expected 1", sc); end
        checks++; if (ic !== 4'd1) begin errors++; $display("FAIL syn_iter_count: got %0d expected 1", ic); end
        checks++; if (nr !== 16)   begin errors++; $display("FAIL syn_reads: got %0d expected 16", nr); end
        bus.SYNDROME_OK = 0;
    endtask

    task automatic test_wr_stall();
        bus.SYNDROME_OK = 0;
        start_decode(1);
        wait_rd(7);
        @(negedge clk);
        @(negedge clk);
        bus.WR_READY = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.WR_EN, bus.CN_CLK_STATE, bus.RD_EN} !== 3'b110 || bus.WR_ADDR !== 4'd7) begin
                errors++;
                $display("FAIL stall_hold_%0d: got we/cs/re=%b addr=%0d expected 110 addr=7", i,
                         {bus.WR_EN, bus.CN_CLK_STATE, bus.RD_EN}, bus.WR_ADDR);
            end
        end
        bus.WR_READY = 1;
        @(negedge clk);
        checks++;
        if (bus.RD_EN !== 1'b1 || bus.RD_ADDR !== 4'd8) begin
            errors++;
            $display("FAIL stall_next_row: got re=%b addr=%0d expected re=1 addr=8", bus.RD_EN, bus.RD_ADDR);
        end
        run_to_done(9, dk, nr, re, lo, fw, sc, ic);
        checks++; if (re !== 0 || nr !== 7) begin errors++; $display("FAIL stall_rest: got %0d reads %0d bad expected 7 reads 0 bad", nr, re); end
        checks++; if (ic !== 4'd1) begin errors++; $display("FAIL stall_iter_count: got %0d expected 1", ic); end
    endtask

    task automatic test_back_to_back();
        bus.SYNDROME_OK = 0;
        start_decode(1);
        repeat (3) @(negedge clk);
        start_decode(5);
        run_to_done(1, dk, nr, re, lo, fw, sc, ic);
        checks++; if (dk !== 63) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 63", dk); end
        checks++; if (ic !== 4'd1) begin errors++; $display("FAIL b2b_iter_count: got %0d expected 1", ic); end
        checks++; if (re !== 0 || nr !== 15) begin errors++; $display("FAIL b2b_reads: got %0d reads %0d bad expected 15 reads 0 bad", nr, re); end
    endtask

    task automatic test_clamp();
        bus.SYNDROME_OK = 0;
        start_decode(0);
        run_to_done(0, dk, nr, re, lo, fw, sc, ic);
        checks++; if (ic !== 4'd1 || dk !== 66) begin errors++; $display("FAIL limit0: got iter=%0d done=%0d expected iter=1 done=66", ic, dk); end
        start_decode(15);
        run_to_done(0, dk, nr, re, lo, fw, sc, ic);
        checks++; if (ic !== 4'd10 || dk !== 651) begin errors++; $display("FAIL limit15: got iter=%0d done=%0d expected iter=10 done=651", ic, dk); end
        checks++; if (nr !== 160 || re !== 0) begin errors++; $display("FAIL limit15_reads: got %0d reads %0d bad expected 160 reads 0 bad", nr, re); end
    endtask

    task automatic test_abort();
        logic seen_done = 1'b0;
        bus.SYNDROME_OK = 0;
        start_decode(3);
        wait_rd(3);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.CN_CLK_STATE !== 1'b0) begin errors++; $display("FAIL abort_phase: got %b expected 0", bus.CN_CLK_STATE); end
        bus.ABORT = 1;
        @(negedge clk);
        bus.ABORT = 0;
        checks++;
        if ({bus.BUSY, bus.DONE, bus.RD_EN, bus.WR_EN, bus.CN_CLK_STATE, bus.CN_RST} !== 6'b000011) begin
            errors++;
            $display("FAIL abort_next: got %b expected 000011",
                     {bus.BUSY, bus.DONE, bus.RD_EN, bus.WR_EN, bus.CN_CLK_STATE, bus.CN_RST});
        end
        @(negedge clk);
        checks++;
        if (bus.CN_RST !== 1'b0) begin errors++; $display("FAIL abort_cn_rst_pulse: got %b expected 0", bus.CN_RST); end
        repeat (10) begin
            @(negedge clk);
            if (bus.DONE || bus.BUSY) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got activity expected idle"); end
        checks++; if (bus.ITER_COUNT !== 4'd0) begin errors++; $display("FAIL abort_iter_held: got %0d expected 0", bus.ITER_COUNT); end
        bus.START = 1; bus.ABORT = 1;
        @(negedge clk);
        bus.START = 0; bus.ABORT = 0;
        checks++;
        if ({bus.BUSY, bus.CN_RST} !== 2'b00) begin errors++; $display("FAIL start_abort_idle: got %b expected 00", {bus.BUSY, bus.CN_RST}); end
        bus.SYNDROME_OK = 1;
        start_decode(4);
        run_to_done(0, dk, nr, re, lo, fw, sc, ic);
        checks++; if (re !== 0 || dk !== 66 || sc !== 1'b1) begin errors++; $display("FAIL abort_restart: got bad=%0d done=%0d succ=%b expected 0 66 1", re, dk, sc); end
    endtask

    task automatic test_async_reset();
        logic found = 1'b0;
        bus.SYNDROME_OK = 0;
        start_decode(1);
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = bus.WR_EN;
        end
        checks++; if (!found) begin errors++; $display("FAIL async_wr_seen: got no write expected write"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.BUSY, bus.DONE, bus.SUCCESS, bus.RD_EN, bus.WR_EN, bus.CN_CLK_STATE, bus.CN_RST} !== 7'b0000011) begin
            errors++;
            $display("FAIL async_reset_out: got %b expected 0000011",
                     {bus.BUSY, bus.DONE, bus.SUCCESS, bus.RD_EN, bus.WR_EN, bus.CN_CLK_STATE, bus.CN_RST});
        end
        checks++;
        if ({bus.ITER_COUNT, bus.RD_ADDR, bus.WR_ADDR} !== 12'h0) begin
            errors++;
            $display("FAIL async_reset_counts: got %h expected 000", {bus.ITER_COUNT, bus.RD_ADDR, bus.WR_ADDR});
        end
        bus.START = 1;
        @(negedge clk);
        bus.START = 0;
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL start_in_reset: got %b expected 0", bus.BUSY); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.CN_RST !== 1'b0) begin errors++; $display("FAIL async_cn_rst_release: got %b expected 0", bus.CN_RST); end
        bus.SYNDROME_OK = 1;
        start_decode(1);
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL start_after_release: got %b expected 1", bus.BUSY); end
        run_to_done(0, dk, nr, re, lo, fw, sc, ic);
        checks++; if (dk !== 66 || re !== 0) begin errors++; $display("FAIL async_rerun: got done=%0d bad=%0d expected 66 0", dk, re); end
    endtask

    initial begin
        test_reset();
        test_two_iter();
        test_syndrome();
        test_wr_stall();
        test_back_to_back();
        test_clamp();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/check_node_scheduler.md
Name: check_node_scheduler

Overview:
- Sequences one CheckNode datapath instance over all check rows of the parity-check matrix, for up to a configurable number of decoding iterations.
- Per check row it:
  - reads the packed input messages and matrix coefficients from the message memory;
  - drives the CheckNode's two-phase CLK_STATE/STATE protocol;
  - writes the quantised extrinsic LLRs back.
- Sits between the decoder top-level control (START/DONE) and the CheckNode plus message memory.

Parameters:
- NUM_CHECKS, 16, number of check rows scheduled per iteration
- CHECK_BIT, 4, width of the check-row address (ceil(log2(NUM_CHECKS)))
- MAX_ITER, 10, hard iteration ceiling
- ITER_BIT, 4, width of iteration counters (ceil(log2(MAX_ITER+1)))

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-low reset
- START  in  1  begin decode; sampled in IDLE only
- ITER_LIMIT  in  ITER_BIT  requested iterations; sampled with START
- ABORT  in  1  cancel decode; highest priority after RST
- SYNDROME_OK  in  1  all parity checks satisfied; sampled in ITER_END only
- BUSY  out  1  high from accepted START until DONE cycle inclusive
- DONE  out  1  one-cycle pulse at end of decode
- SUCCESS  out  1  valid with DONE: 1 = syndrome satisfied
- ITER_COUNT  out  ITER_BIT  completed iterations; held after DONE until next START
- RD_EN  out  1  message-memory read strobe; data returns next cycle
- RD_ADDR  out  CHECK_BIT  check row being read
- WR_EN  out  1  write strobe for CheckNode OUTPUT_LLR
- WR_ADDR  out  CHECK_BIT  check row being written
- WR_READY  in  1  memory accepts write this cycle
- CN_CLK_STATE  out  1  to CheckNode CLK_STATE: 0 = advance, 1 = hold
- CN_RST  out  1  to CheckNode RST (active-high, synchronous in CheckNode)

Behaviour:
- Reset (RST=0, async) values:
  - state IDLE; BUSY=0, DONE=0, SUCCESS=0, ITER_COUNT=0;
  - RD_EN=0, WR_EN=0, RD_ADDR=0, WR_ADDR=0;
  - CN_CLK_STATE=1, CN_RST=1.
- CN_RST deasserts on the first clock after RST release. CheckNode STATE is then 0.
- States: IDLE, READ, LOAD, PHASE, WRITE, ITER_END, FINISH.
- IDLE:
  - CN_CLK_STATE=1.
  - On START: latch limit = (ITER_LIMIT==0) ? 1 : min(ITER_LIMIT, MAX_ITER); check=0; iter=0; ITER_COUNT=0; BUSY=1; go to READ.
- READ: RD_EN=1, RD_ADDR=check. Go to LOAD.
- LOAD:
  - Memory data is on the CheckNode BUF_LLR/INPUT_MATRIX pins.
  - CN_CLK_STATE=0, so CheckNode loads INPUT_LLR and sets STATE 0->1.
  - Go to PHASE.
- PHASE:
  - CN_CLK_STATE=0, so CheckNode captures the first-half propagation and sets STATE 1->0.
  - Go to WRITE.
- WRITE:
  - CN_CLK_STATE=1 (hold), so CheckNode outputs are stable. WR_EN=1, WR_ADDR=check.
  - If WR_READY=0, stay in WRITE with WR_EN held.
  - On WR_READY=1:
    - if check==NUM_CHECKS-1, go to ITER_END;
    - else check++ and go to READ.
- Steady-state cost: 4 cycles per check row. Latency START -> first WR_EN = 4 cycles.
- ITER_END (1 cycle):
  - iter++; ITER_COUNT=iter+1.
  - If SYNDROME_OK=1: SUCCESS=1, go to FINISH.
  - Else if iter+1==limit: SUCCESS=0, go to FINISH.
  - Else check=0, go to READ.
- FINISH: DONE=1 for one cycle, BUSY=1 this cycle, then BUSY=0 and go to IDLE.
- CN_CLK_STATE is 0 only in LOAD and PHASE. This guarantees the CheckNode STATE is 0 whenever the scheduler is in READ or IDLE.
- ABORT (any non-IDLE state):
  - Next cycle: state IDLE, BUSY=0, DONE=0, RD_EN=0, WR_EN=0, CN_CLK_STATE=1.
  - CN_RST=1 for exactly one cycle to re-align the CheckNode STATE. ITER_COUNT is held.
  - ABORT in IDLE is ignored.
- START while BUSY is ignored. START and ABORT in the same IDLE cycle: ABORT wins, nothing starts.
- Async reset mid-decode: immediate return to reset values; the in-flight write is dropped.

Decomposition:
- Shared package:
  - sched_state_t enum (7 states);
  - CN_CYCLES_PER_CHECK=4;
  - width helper constants CHECK_BIT/ITER_BIT derived via clog2.
- One sub-module, sched_iter_counter, is natural:
  - holds the check and iteration counters;
  - implements the limit clamp;
  - flags last_check and last_iter.
- The FSM stays in check_node_scheduler.

Test Plan:
- Reset then START, ITER_LIMIT=2, SYNDROME_OK=0, WR_READY=1 -> RD_ADDR 0..15 twice; CN_CLK_STATE=0 exactly 64 cycles; DONE at cycle 132 after START; SUCCESS=0; ITER_COUNT=2.
- ITER_LIMIT=5, SYNDROME_OK=1 at the first ITER_END -> DONE after 1 iteration; SUCCESS=1; ITER_COUNT=1.
- WR_READY held low 3 cycles at check 7 -> WR_EN and WR_ADDR=7 stable for 4 cycles; CN_CLK_STATE=1 throughout; no RD_EN; row 8 read afterwards.
- ABORT during PHASE of check 3 -> next cycle IDLE, BUSY=0, one-cycle CN_RST pulse; a following START restarts at RD_ADDR=0 with no DONE from the aborted run.
- ITER_LIMIT=0 and ITER_LIMIT=15 (MAX_ITER=10) -> 1 and 10 iterations run respectively; ITER_COUNT=1 and 10.
- RST pulled low mid-WRITE -> all outputs at reset values asynchronously; CN_RST=1; START is accepted only after release.
